// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with fixed wait states,
// RV32I load/store sizing, little-endian lanes and access error reporting.
module mem_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_fun3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT_ST, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [2:0]         fun3_q, fun3_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [31:0]        mem_q [DEPTH];

  logic               a_we;
  logic [31:0]        a_addr;
  logic [2:0]         a_fun3;
  logic [31:0]        a_wdata;
  logic [ADDR_W-1:0]  idx_c;
  logic [4:0]         sh_c;
  logic [31:0]        word_c, shifted_c, load_c, mask_c, lane_c, merged_c;
  logic               err_c, enter_resp_c, mem_we_c;

  // Access operands: live request when entering RESP straight from IDLE, else latched copy
  always_comb begin
    a_we    = (state_q == IDLE) ? req_we    : we_q;
    a_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    a_fun3  = (state_q == IDLE) ? req_fun3  : fun3_q;
    a_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  end

  // Decode legality, extract load result and build the merged store word
  always_comb begin
    err_c     = 1'b0;
    idx_c     = a_addr[ADDR_W+1:2];
    sh_c      = {a_addr[1:0], 3'b000};
    word_c    = mem_q[idx_c];
    shifted_c = word_c >> sh_c;
    load_c    = 32'd0;
    mask_c    = 32'd0;
    lane_c    = 32'd0;
    if (a_we) begin
      if (a_fun3 > 3'd2) err_c = 1'b1;
    end else begin
      if (a_fun3 == 3'd3 || a_fun3 >= 3'd6) err_c = 1'b1;
    end
    if (a_fun3[1:0] == 2'd1 && a_addr[0]) err_c = 1'b1;
    if (a_fun3[1:0] == 2'd2 && a_addr[1:0] != 2'b00) err_c = 1'b1;
    if ((a_addr >> (ADDR_W + 2)) != 32'd0) err_c = 1'b1;
    case (a_fun3)
      3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b010:  load_c = word_c;
      3'b100:  load_c = {24'd0, shifted_c[7:0]};
      3'b101:  load_c = {16'd0, shifted_c[15:0]};
      default: load_c = 32'd0;
    endcase
    case (a_fun3[1:0])
      2'd0: begin
        mask_c = 32'h0000_00FF << sh_c;
        lane_c = {4{a_wdata[7:0]}};
      end
      2'd1: begin
        mask_c = 32'h0000_FFFF << sh_c;
        lane_c = {2{a_wdata[15:0]}};
      end
      default: begin
        mask_c = 32'hFFFF_FFFF;
        lane_c = a_wdata;
      end
    endcase
    merged_c = (word_c & ~mask_c) | (lane_c & mask_c);
  end

  // Next-state, request latch and response capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    fun3_d       = fun3_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enter_resp_c = 1'b0;
    mem_we_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          fun3_d  = req_fun3;
          wdata_d = req_wdata;
          if (WAIT == 0) begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = WAIT_ST;
            cnt_d   = CNT_W'(WAIT);
          end
        end
      end
      WAIT_ST: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = RESP;
          cnt_d        = CNT_W'(0);
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp_c) begin
      err_d    = err_c;
      rdata_d  = (err_c || a_we) ? 32'd0 : load_c;
      mem_we_c = a_we && !err_c && rst;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_W'(0);
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      fun3_q  <= 3'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      fun3_q  <= fun3_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[idx_c] <= merged_c;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors against a transaction-level memory model.
module tb_mem_responder;

  localparam int unsigned ADDR_W_TB = 10;
  localparam int unsigned WAIT_TB   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_fun3 = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  mem_responder #(.ADDR_W(ADDR_W_TB), .WAIT(WAIT_TB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_fun3(req_fun3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [int unsigned];
  bit          m_busy = 1'b0;
  int          m_n = 0;
  bit          m_we;
  logic [31:0] m_addr, m_wd;
  logic [2:0]  m_f3;
  logic [31:0] m_rd = 32'd0;
  bit          m_er = 1'b0;

  function automatic void model_access();
    int unsigned sz, idx, sh;
    logic [31:0] w, v, msk;
    bit bad;
    sz  = int'(m_f3[1:0]);
    bad = m_we ? (m_f3 > 3'd2) : !(m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (sz == 1 && (m_addr % 2) != 0) bad = 1'b1;
    if (sz == 2 && (m_addr % 4) != 0) bad = 1'b1;
    if (m_addr >= (32'd4 << ADDR_W_TB)) bad = 1'b1;
    m_er = bad;
    m_rd = 32'd0;
    if (bad) return;
    idx = m_addr / 4;
    sh  = (m_addr % 4) * 8;
    w   = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
    if (m_we) begin
      msk = (sz == 0) ? (32'hFF << sh) : (sz == 1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
      m_mem[idx] = (w & ~msk) | ((m_wd << sh) & msk);
    end else begin
      v = w >> sh;
      case (m_f3)
        3'd0: m_rd = v[7] ? (v | 32'hFFFF_FF00) : (v & 32'hFF);
        3'd1: m_rd = v[15] ? (v | 32'hFFFF_0000) : (v & 32'hFFFF);
        3'd4: m_rd = v & 32'hFF;
        3'd5: m_rd = v & 32'hFFFF;
        default: m_rd = w;
      endcase
    end
  endfunction

  // Track one outstanding transaction: accept, WAIT cycles, response, consume
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_n    = 0;
    end else if (m_busy) begin
      if (m_n >= WAIT_TB) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        m_n = m_n + 1;
        if (m_n == WAIT_TB) model_access();
      end
    end else if (req_valid) begin
      m_we = req_we; m_addr = req_addr; m_f3 = req_fun3; m_wd = req_wdata;
      m_busy = 1'b1;
      m_n    = 0;
      if (WAIT_TB == 0) model_access();
    end
  end

  // Per-cycle comparison of handshake and response against the model
  always @(negedge clk) begin
    bit ev;
    ev = m_busy && (m_n >= WAIT_TB);
    checks++;
    if (req_ready !== !m_busy) begin
      errors++;
      $display("FAIL req_ready t=%0t got %b want %b", $time, req_ready, !m_busy);
    end
    checks++;
    if (rsp_valid !== ev) begin
      errors++;
      $display("FAIL rsp_valid t=%0t got %b want %b", $time, rsp_valid, ev);
    end
    if (ev || !rst) begin
      checks++;
      if (rsp_rdata !== (rst ? m_rd : 32'd0)) begin
        errors++;
        $display("FAIL rsp_rdata t=%0t got %h want %h", $time, rsp_rdata, rst ? m_rd : 32'd0);
      end
      checks++;
      if (rsp_err !== (rst ? m_er : 1'b0)) begin
        errors++;
        $display("FAIL rsp_err t=%0t got %b want %b", $time, rsp_err, rst ? m_er : 1'b0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd;
    int          hold;
    bit          pulse;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  vec_t vecs[$];

  task automatic send(input vec_t v, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_fun3 = v.f3; req_wdata = v.wd;
    n = 0;
    rd = 32'hX; er = 1'bX; lat = -1;
    while (n < 40) begin
      @(posedge clk); #2;
      n++;
      if (n == 1) begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
      end
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      errors++;
      $display("FAIL timeout addr=%h got no rsp_valid want rsp_valid=1", v.addr);
      return;
    end
    lat = n; rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < v.hold; i++) begin
      if (v.pulse && i == 2) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_fun3 = 3'd2; req_wdata = 32'h0;
      end else begin
        req_valid = 1'b0; req_we = 1'b0;
      end
      @(posedge clk); #2;
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    rsp_ready = 1'b0;
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    vecs.push_back('{1'b1, 32'h10,   3'd2, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h13,   3'd0, 32'h0,        0, 1'b0, 32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b0, 32'h13,   3'd4, 32'h0,        0, 1'b0, 32'h000000DE, 1'b0});
    vecs.push_back('{1'b0, 32'h12,   3'd1, 32'h0,        0, 1'b0, 32'hFFFFDEAD, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd5, 32'h0,        0, 1'b0, 32'h0000BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h11,   3'd0, 32'h00000055, 0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        0, 1'b0, 32'hDEAD55EF, 1'b0});
    vecs.push_back('{1'b0, 32'h12,   3'd2, 32'h0,        0, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h11,   3'd1, 32'h0000AAAA, 0, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h1000, 3'd2, 32'h0,        0, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,   3'd3, 32'h0,        0, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h10,   3'd4, 32'h0,        0, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        5, 1'b1, 32'hDEAD55EF, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        0, 1'b0, 32'hDEAD55EF, 1'b0});
    vecs.push_back('{1'b1, 32'h14,   3'd2, 32'h11223344, 0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h16,   3'd1, 32'h9999ABCD, 0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h14,   3'd2, 32'h0,        0, 1'b0, 32'hABCD3344, 1'b0});
    vecs.push_back('{1'b0, 32'h15,   3'd0, 32'h0,        0, 1'b0, 32'h00000033, 1'b0});
    vecs.push_back('{1'b0, 32'h16,   3'd1, 32'h0,        0, 1'b0, 32'hFFFFABCD, 1'b0});
    vecs.push_back('{1'b1, 32'hFFC,  3'd2, 32'h80000001, 0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'hFFF,  3'd0, 32'h0,        0, 1'b0, 32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 32'h1002, 3'd5, 32'h0,        0, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h20,   3'd2, 32'hCAFEF00D, 0, 1'b0, 32'h0,        1'b0});

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    foreach (vecs[k]) begin
      send(vecs[k], rd, er, lat);
      check_lit($sformatf("rdata[%0d]", k), rd, vecs[k].rd);
      check_lit($sformatf("err[%0d]", k), 32'(er), 32'(vecs[k].er));
      check_lit($sformatf("latency[%0d]", k), 32'(lat), 32'(WAIT_TB + 1));
    end

    // Store aborted by reset while waiting must leave memory alone
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_fun3 = 3'd2; req_wdata = 32'h12345678;
    @(posedge clk); #2;
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b0;
    #1;
    check_lit("ready_in_reset", 32'(req_ready), 32'd1);
    check_lit("valid_in_reset", 32'(rsp_valid), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_lit("ready_after_reset", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    send('{1'b0, 32'h20, 3'd2, 32'h0, 0, 1'b0, 32'hCAFEF00D, 1'b0}, rd, er, lat);
    check_lit("rdata_after_abort", rd, 32'hCAFEF00D);
    check_lit("err_after_abort", 32'(er), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
